// File: rtl/icache_dm_if.sv
// SRAM-like request/response bus used on both sides of the instruction cache.
interface icache_dm_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with in-order whole-line refill.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_dm #(
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  icache_dm_if.slave  cpu_inst,
  icache_dm_if.master cache_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] stat_hit_cnt,
  output logic [31:0] stat_miss_cnt
`endif
);

  localparam int unsigned TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned WORD_WIDTH = OFFSET_WIDTH - 2;
  localparam int unsigned LINE_WORDS = 1 << WORD_WIDTH;
  localparam int unsigned NUM_LINES  = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [WORD_WIDTH-1:0]   word_q;
  logic [WORD_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_LINES-1:0]    valid_q;

  logic [TAG_WIDTH-1:0]    tag_arr  [NUM_LINES];
  logic [31:0]             data_arr [NUM_LINES][LINE_WORDS];

  logic hit_c;
  logic addr_ok_c;
  logic data_ok_c;
  logic mem_req_c;
  logic latch_c;
  logic clr_valid_c;
  logic fill_c;
  logic done_c;
  logic unused_c;

  assign hit_c = valid_q[index_q] && (tag_arr[index_q] == tag_q);

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_ok_c   = 1'b0;
    data_ok_c   = 1'b0;
    mem_req_c   = 1'b0;
    latch_c     = 1'b0;
    clr_valid_c = 1'b0;
    fill_c      = 1'b0;
    done_c      = 1'b0;
    case (state_q)
      IDLE: begin
        addr_ok_c = cpu_inst.req;
        if (cpu_inst.req) begin
          latch_c = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_c) begin
          data_ok_c = 1'b1;
          addr_ok_c = cpu_inst.req;
          if (cpu_inst.req) latch_c = 1'b1;
          else              state_d = IDLE;
        end else begin
          clr_valid_c = 1'b1;
          cnt_d       = '0;
          state_d     = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_c = 1'b1;
        if (cache_inst.addr_ok) state_d = MISS_WAIT;
      end
      MISS_WAIT: begin
        if (cache_inst.data_ok) begin
          fill_c = 1'b1;
          cnt_d  = WORD_WIDTH'(cnt_q + 1'b1);
          if (cnt_q == WORD_WIDTH'(LINE_WORDS - 1)) begin
            done_c  = 1'b1;
            state_d = RESP;
          end else begin
            state_d = MISS_REQ;
          end
        end
      end
      RESP: begin
        data_ok_c = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      index_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_c)     {tag_q, index_q, word_q} <= cpu_inst.addr[31:2];
      if (clr_valid_c) valid_q[index_q] <= 1'b0;
      if (done_c)      valid_q[index_q] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; validity alone gates their use
  always_ff @(posedge clk) begin
    if (fill_c) data_arr[index_q][cnt_q] <= cache_inst.rdata;
    if (done_c) tag_arr[index_q] <= tag_q;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit_c) stat_hit_cnt  <= stat_hit_cnt + 32'd1;
      else       stat_miss_cnt <= stat_miss_cnt + 32'd1;
    end
  end
`endif

  assign cpu_inst.addr_ok = addr_ok_c;
  assign cpu_inst.data_ok = data_ok_c;
  assign cpu_inst.rdata   = data_ok_c ? data_arr[index_q][word_q] : 32'd0;

  assign cache_inst.req   = mem_req_c;
  assign cache_inst.wr    = 1'b0;
  assign cache_inst.size  = 2'b10;
  assign cache_inst.addr  = mem_req_c ? {tag_q, index_q, cnt_q, 2'b00} : 32'd0;
  assign cache_inst.wdata = 32'd0;

  // Fetch-only: write controls, size and byte offset carry no information
  assign unused_c = ^{cpu_inst.wr, cpu_inst.size, cpu_inst.wdata, cpu_inst.addr[1:0]};

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: vector table of fetches plus refill corner sequences.
module tb_icache_dm;

  logic clk;
  logic resetn;

  icache_dm_if cpu_bus ();
  icache_dm_if mem_bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] stat_hit_cnt;
  logic [31:0] stat_miss_cnt;
`endif

  icache_dm dut (
    .clk        (clk),
    .resetn     (resetn),
    .cpu_inst   (cpu_bus),
    .cache_inst (mem_bus)
`ifdef ICACHE_STATS_EN
    ,
    .stat_hit_cnt  (stat_hit_cnt),
    .stat_miss_cnt (stat_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory model state
  int          addr_dly   = 0;
  int          data_dly   = 0;
  int          mem_reads  = 0;
  int          proto_err  = 0;
  logic [31:0] rd_log [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Memory: acts on the negedge, returns ~addr as the word, one transaction at a time
  initial begin : mem_model
    int          req_wait;
    int          dwait;
    bit          pending;
    bit          aok;
    bit          dok;
    logic [31:0] paddr;
    logic [31:0] held;
    req_wait = 0; dwait = 0; pending = 0; aok = 0; dok = 0; paddr = '0; held = '0;
    mem_bus.addr_ok = 1'b0;
    mem_bus.data_ok = 1'b0;
    mem_bus.rdata   = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pending = 0; req_wait = 0; aok = 0; dok = 0;
      end else begin
        if (aok) begin
          pending = 1; paddr = held; dwait = 0;
          mem_reads++;
          rd_log.push_back(held);
        end
        if (dok) pending = 0;
        aok = 0; dok = 0;
        if (pending) begin
          if (dwait >= data_dly) dok = 1;
          else dwait++;
        end
        if (mem_bus.req && pending) proto_err++;
        if (mem_bus.req && !pending) begin
          if (req_wait > 0 && mem_bus.addr !== held) proto_err++;
          held = mem_bus.addr;
          if (req_wait >= addr_dly) begin aok = 1; req_wait = 0; end
          else req_wait++;
        end else begin
          if (req_wait > 0) proto_err++;
          req_wait = 0;
        end
      end
      mem_bus.addr_ok = aok;
      mem_bus.data_ok = dok;
      if (dok) mem_bus.rdata = ~paddr;
    end
  end

  // One fetch; hold keeps req asserted during the miss to probe addr_ok
  task automatic fetch(input logic [31:0] a, input bit hold,
                       output logic [31:0] d, output int lat, output int viol);
    int n;
    d = '0; lat = -1; viol = 0;
    @(negedge clk);
    cpu_bus.req  = 1'b1;
    cpu_bus.addr = a;
    #1;
    n = 0;
    while (!cpu_bus.addr_ok && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!cpu_bus.addr_ok) begin
      fail_timeout("fetch_addr_ok");
      cpu_bus.req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!hold) cpu_bus.req = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk); #1;
      if (cpu_bus.data_ok) begin
        lat = i; d = cpu_bus.rdata;
        break;
      end
      if (cpu_bus.addr_ok) viol++;
    end
    cpu_bus.req = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_reads;
  } vec_t;

  localparam int NV = 8;
  vec_t vec [NV];

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] d;
    int          lat;
    int          viol;
    int          r0;
    int          n;
    logic [31:0] base;

    vec[0] = '{32'h1FC00000, 32'hE03FFFFF, 10, 4};
    vec[1] = '{32'h1FC00008, 32'hE03FFFF7,  1, 0};
    vec[2] = '{32'h1FC0000C, 32'hE03FFFF3,  1, 0};
    vec[3] = '{32'h00001000, 32'hFFFFEFFF, 10, 4};
    vec[4] = '{32'h00001400, 32'hFFFFEBFF, 10, 4};
    vec[5] = '{32'h00001000, 32'hFFFFEFFF, 10, 4};
    vec[6] = '{32'h0000100C, 32'hFFFFEFF3,  1, 0};
    vec[7] = '{32'h00000104, 32'hFFFFFEFB, 10, 4};

    resetn        = 1'b0;
    cpu_bus.req   = 1'b0;
    cpu_bus.wr    = 1'b0;
    cpu_bus.size  = 2'b10;
    cpu_bus.addr  = '0;
    cpu_bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_addr_ok", 32'(cpu_bus.addr_ok), 32'd0);
    check("rst_data_ok", 32'(cpu_bus.data_ok), 32'd0);
    check("rst_rdata",   cpu_bus.rdata,        32'd0);
    check("rst_mem_req", 32'(mem_bus.req),     32'd0);
    check("rst_mem_addr", mem_bus.addr,        32'd0);
    check("rst_mem_size", 32'(mem_bus.size),   32'd2);
    check("rst_mem_wr",  32'(mem_bus.wr),      32'd0);
    check("rst_mem_wdata", mem_bus.wdata,      32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_stat_hit",  stat_hit_cnt,  32'd0);
    check("rst_stat_miss", stat_miss_cnt, 32'd0);
`endif
    resetn = 1'b1;

    // Zero-wait memory vector table
    for (int i = 0; i < NV; i++) begin
      r0 = mem_reads;
      fetch(vec[i].addr, 1'b0, d, lat, viol);
      check($sformatf("v%0d_data", i),  d,                      vec[i].exp_data);
      check($sformatf("v%0d_lat", i),   32'(lat),               32'(vec[i].exp_lat));
      check($sformatf("v%0d_reads", i), 32'(mem_reads - r0),    32'(vec[i].exp_reads));
      if (vec[i].exp_reads == 4 && mem_reads - r0 == 4) begin
        base = vec[i].addr & 32'hFFFFFFF0;
        for (int k = 0; k < 4; k++)
          check($sformatf("v%0d_raddr%0d", i, k), rd_log[r0 + k], base + 32'(4 * k));
      end
`ifdef ICACHE_STATS_EN
      if (i == 1) begin
        check("stat_hit",  stat_hit_cnt,  32'd1);
        check("stat_miss", stat_miss_cnt, 32'd1);
      end
`endif
    end

    // Streaming hits on resident line 0x100
    r0 = mem_reads;
    @(negedge clk);
    cpu_bus.req  = 1'b1;
    cpu_bus.addr = 32'h00000100;
    #1;
    check("stream_accept", 32'(cpu_bus.addr_ok), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) cpu_bus.addr = 32'h00000104 + 32'(4 * i);
      else       cpu_bus.req  = 1'b0;
      @(negedge clk); #1;
      check($sformatf("stream%0d_ok", i),   32'(cpu_bus.data_ok), 32'd1);
      check($sformatf("stream%0d_data", i), cpu_bus.rdata,        ~(32'h00000100 + 32'(4 * i)));
    end
    check("stream_reads", 32'(mem_reads - r0), 32'd0);

    // Slow memory; req held high to confirm no accept during refill
    addr_dly  = 5;
    data_dly  = 3;
    proto_err = 0;
    r0 = mem_reads;
    fetch(32'h00002028, 1'b1, d, lat, viol);
    check("slow_data",  d,                   32'hFFFFDFD7);
    check("slow_lat",   32'(lat),            32'd42);
    check("slow_viol",  32'(viol),           32'd0);
    check("slow_reads", 32'(mem_reads - r0), 32'd4);
    check("slow_proto", 32'(proto_err),      32'd0);
    addr_dly = 0;
    data_dly = 0;

    // Reset after two refill words
    r0 = mem_reads;
    @(negedge clk);
    cpu_bus.req  = 1'b1;
    cpu_bus.addr = 32'h00003004;
    #1;
    @(posedge clk); #1;
    cpu_bus.req = 1'b0;
    n = 0;
    while (mem_reads - r0 < 2 && n < 100) begin
      @(negedge clk); n++;
    end
    if (mem_reads - r0 < 2) fail_timeout("mid_refill_wait");
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_mem_req",  32'(mem_bus.req),     32'd0);
    check("midrst_mem_addr", mem_bus.addr,         32'd0);
    check("midrst_data_ok",  32'(cpu_bus.data_ok), 32'd0);
    check("midrst_addr_ok",  32'(cpu_bus.addr_ok), 32'd0);
    check("midrst_rdata",    cpu_bus.rdata,        32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    r0 = mem_reads;
    fetch(32'h00003004, 1'b0, d, lat, viol);
    check("refetch_data",  d,                   32'hFFFFCFFB);
    check("refetch_lat",   32'(lat),            32'd10);
    check("refetch_reads", 32'(mem_reads - r0), 32'd4);
    check("proto_final",   32'(proto_err),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
